// File: rtl/strobe_gen_multi.sv
// -----------------------------------------------------------------------------
// strobe_gen_multi
//
// Multi-channel strobe generator. A shared prescaler divides the input clock
// down to a 1 kHz base tick. Each channel divides that tick by its own run-time
// programmable divider and emits one-clock-wide strobes, periodically or once.
// A global sync pulse restarts the prescaler and every channel phase so that
// channels with equal dividers strobe together.
//
// Parameters
//   INPUT_FREQUENCY_KHZ  clock frequency in kHz (2 .. 65535)
//   N_CH                 number of channels (1 .. 16)
//   DIV_W                width of the per-channel divider, in base ticks
//   CH_W                 channel-select width, max(1, clog2(N_CH)); derived,
//                        leave at its default
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   sync_i         one-cycle pulse: restart prescaler and all channel phases
//   cfg_we_i       channel configuration write strobe
//   cfg_ch_i       target channel; values >= N_CH are ignored
//   cfg_div_i      channel period in base ticks (0 and 1 both mean every tick)
//   cfg_en_i       channel enable
//   cfg_oneshot_i  1 = one-shot, 0 = periodic
//   tick_1k_o      registered 1 kHz base strobe, one clock wide
//   stb_o          registered per-channel strobes, one clock wide each
//   active_o       registered per-channel enable status
// -----------------------------------------------------------------------------
module strobe_gen_multi #(
   parameter int INPUT_FREQUENCY_KHZ = 10000,
   parameter int N_CH                = 4,
   parameter int DIV_W               = 10,
   parameter int CH_W                = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              sync_i,
   input  logic              cfg_we_i,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [DIV_W-1:0]  cfg_div_i,
   input  logic              cfg_en_i,
   input  logic              cfg_oneshot_i,
   output logic              tick_1k_o,
   output logic [N_CH-1:0]   stb_o,
   output logic [N_CH-1:0]   active_o
);

   localparam int              PS_W      = $clog2(INPUT_FREQUENCY_KHZ);
   localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(INPUT_FREQUENCY_KHZ - 1);

   // Reload value for a channel counter: div-1, saturating at 0 so that
   // dividers of 0 and 1 both strobe on every base tick.
   function automatic logic [DIV_W-1:0] ld_of(input logic [DIV_W-1:0] div);
      return (div <= DIV_W'(1)) ? '0 : div - DIV_W'(1);
   endfunction

   // --------------------------------------------------------------------------
   // Prescaler: counts down to 0, then emits one base tick and reloads.
   // --------------------------------------------------------------------------
   logic [PS_W-1:0] ps_q, ps_d;
   logic            tick_q, tick_d;

   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      ps_d   = ps_q - PS_W'(1);
      tick_d = 1'b0;
      if (sync_i) begin
         ps_d = PS_RELOAD;
      end else if (ps_q == '0) begin
         ps_d   = PS_RELOAD;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst_ni) begin
         ps_q   <= PS_RELOAD;
         tick_q <= 1'b0;
      end else begin
         ps_q   <= ps_d;
         tick_q <= tick_d;
      end
   end

   // --------------------------------------------------------------------------
   // Channels
   // --------------------------------------------------------------------------
   logic [DIV_W-1:0] div_q [N_CH];
   logic [DIV_W-1:0] div_d [N_CH];
   logic [DIV_W-1:0] cnt_q [N_CH];
   logic [DIV_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]  en_q, en_d;
   logic [N_CH-1:0]  oneshot_q, oneshot_d;
   logic [N_CH-1:0]  stb_q, stb_d;
   logic [N_CH-1:0]  ch_wr;

   // Per-channel write select. Only indices below N_CH are compared, so an
   // out-of-range cfg_ch_i selects nothing and the write is dropped.
   always_comb begin
      ch_wr = '0;
      for (int i = 0; i < N_CH; i++) begin
         ch_wr[i] = cfg_we_i && (cfg_ch_i == CH_W'(i));
      end
   end

   // Priority per channel: write > sync > tick step > hold.
   // A write still loads cnt from cfg_div_i when it coincides with sync.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         div_d[i]     = div_q[i];
         cnt_d[i]     = cnt_q[i];
         en_d[i]      = en_q[i];
         oneshot_d[i] = oneshot_q[i];
         stb_d[i]     = 1'b0;

         if (ch_wr[i]) begin
            div_d[i]     = cfg_div_i;
            en_d[i]      = cfg_en_i;
            oneshot_d[i] = cfg_oneshot_i;
            cnt_d[i]     = ld_of(cfg_div_i);
         end else if (sync_i) begin
            cnt_d[i] = ld_of(div_q[i]);
         end else if (tick_q && en_q[i]) begin
            if (cnt_q[i] == '0) begin
               stb_d[i] = 1'b1;
               cnt_d[i] = ld_of(div_q[i]);
               // One-shot channels disable themselves on the strobe, so the
               // status output drops in the same cycle the strobe rises.
               if (oneshot_q[i]) begin
                  en_d[i] = 1'b0;
               end
            end else begin
               // cnt is nonzero here, so the decrement cannot underflow.
               cnt_d[i] = cnt_q[i] - DIV_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the divider/counter arrays are real control state, not a RAM,
         // so every entry is reset; nothing may carry over a reset.
         for (int i = 0; i < N_CH; i++) begin
            div_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         en_q      <= '0;
         oneshot_q <= '0;
         stb_q     <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            div_q[i] <= div_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         en_q      <= en_d;
         oneshot_q <= oneshot_d;
         stb_q     <= stb_d;
      end
   end

   assign tick_1k_o = tick_q;
   assign stb_o     = stb_q;
   assign active_o  = en_q;

endmodule
